// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and
// latency constants for the mul/div sequencer.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_MUL  = 3'd1;
  localparam state_t S_DIV  = 3'd2;
  localparam state_t S_FIX  = 3'd3;
  localparam state_t S_DONE = 3'd4;

  localparam int DIV_ITERS = 32;
  localparam int MUL_LAT   = 2;
  localparam int DIV_LAT   = 34;

endpackage

// File: rtl/div_iter.sv
// div_iter: unsigned 32/32 restoring divider,
// one quotient bit per cycle after a start pulse.
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quo,
  output logic [31:0] o_rem,
  output logic        o_last
);

  logic        r_busy;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_div;
  logic [32:0] w_part;
  logic [32:0] w_diff;

  // partial remainder never exceeds 33 bits,
  // so bit 32 of the difference is the borrow
  assign w_part = {r_rem, r_quo[31]};
  assign w_diff = w_part - {1'b0, r_div};
  assign o_last = r_busy
                & (r_cnt == 5'(DIV_ITERS - 1));
  assign o_quo  = r_quo;
  assign o_rem  = r_rem;

  // load on start, then one restoring step per cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= '0;
      r_div  <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_rem  <= '0;
      r_quo  <= i_dividend;
      r_div  <= i_divisor;
    end else if (r_busy) begin
      if (!w_diff[32]) begin
        r_rem <= w_diff[31:0];
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_part[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
      r_cnt <= r_cnt + 5'd1;
      if (o_last) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: EXE-stage multiply/divide sequencer
// with fixed latency, HI/LO write and flush abort.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_wdata,
  output logic [31:0] lo_wdata
);

  state_t             r_state;
  logic               r_sx;
  logic               r_qneg;
  logic               r_rneg;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [31:0]        r_hi;
  logic [31:0]        r_lo;
  logic               w_is_div;
  logic               w_signed;
  logic               w_launch;
  logic               w_last;
  logic [31:0]        w_amag;
  logic [31:0]        w_bmag;
  logic [31:0]        w_quo;
  logic [31:0]        w_rem;
  logic [31:0]        w_qfix;
  logic [31:0]        w_rfix;
  logic signed [32:0] w_ma;
  logic signed [32:0] w_mb;
  logic signed [63:0] w_prod;

  assign w_is_div = (req_op == OP_DIV)
                  | (req_op == OP_DIVU);
  assign w_signed = (req_op == OP_MULT)
                  | (req_op == OP_DIV);
  assign w_launch = (r_state == S_IDLE)
                  & req_valid & ~flush;

  assign w_amag = (w_signed & req_src1[31])
                ? -req_src1 : req_src1;
  assign w_bmag = (w_signed & req_src2[31])
                ? -req_src2 : req_src2;

  // low 64 bits of the 33x33 product are exact
  assign w_ma   = {r_sx & r_a[31], r_a};
  assign w_mb   = {r_sx & r_b[31], r_b};
  assign w_prod = 64'(w_ma) * 64'(w_mb);

  assign w_qfix = r_qneg ? -w_quo : w_quo;
  assign w_rfix = r_rneg ? -w_rem : w_rem;

  assign done     = (r_state == S_DONE);
  assign hi_we    = done;
  assign lo_we    = done;
  assign hi_wdata = r_hi;
  assign lo_wdata = r_lo;
  assign stall    = req_valid & ~done;

  div_iter u_div (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_launch & w_is_div),
    .i_abort    (flush),
    .i_dividend (w_amag),
    .i_divisor  (w_bmag),
    .o_quo      (w_quo),
    .o_rem      (w_rem),
    .o_last     (w_last)
  );

  // sequencer FSM; flush drops any op back to IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sx    <= 1'b0;
      r_qneg  <= 1'b0;
      r_rneg  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_sx    <= w_signed;
            r_a     <= req_src1;
            r_b     <= req_src2;
            r_qneg  <= w_signed
                     & (req_src1[31] ^ req_src2[31]);
            r_rneg  <= w_signed & req_src1[31];
            r_state <= w_is_div ? S_DIV : S_MUL;
          end
        end
        S_MUL: begin
          r_hi    <= w_prod[63:32];
          r_lo    <= w_prod[31:0];
          r_state <= S_DONE;
        end
        S_DIV: begin
          if (w_last) r_state <= S_FIX;
        end
        S_FIX: begin
          r_hi    <= w_rfix;
          r_lo    <= w_qfix;
          r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: random + directed mul/div ops
// checked each cycle against an arithmetic model.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        flush;
  logic        stall;
  logic        done;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          m_act = 0;
  int          exp_cyc = 0;
  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  muldiv_seq dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_src1 (req_src1),
    .req_src2 (req_src2),
    .flush    (flush),
    .stall    (stall),
    .done     (done),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .hi_wdata (hi_wdata),
    .lo_wdata (lo_wdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)",
               nm, a, e, cyc);
    end
  endtask

  // {hi, lo} straight from the arithmetic definition
  function automatic logic [63:0] model(
      input logic [1:0] op,
      input logic [31:0] a,
      input logic [31:0] b);
    int          sa;
    int          sb;
    longint      p;
    logic [63:0] u;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      2'b01: begin
        u = {32'b0, a} * {32'b0, b};
        return u;
      end
      2'b11: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 0)
          return {a, (sa < 0) ? 32'h1 : 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
          return {32'h0, 32'h80000000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] op);
    return op[1] ? 34 : 2;
  endfunction

  function automatic logic [31:0] rnd_opnd();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // per-cycle compare against the model
  always @(negedge clk) begin
    logic ed;
    if (!reset) begin
      ed = m_act && (cyc == exp_cyc);
      chk("done", 32'(done), 32'(ed));
      chk("hi_we", 32'(hi_we), 32'(ed));
      chk("lo_we", 32'(lo_we), 32'(ed));
      chk("stall", 32'(stall),
          32'(req_valid & ~ed));
      if (ed) begin
        chk("hi_wdata", hi_wdata, exp_hi);
        chk("lo_wdata", lo_wdata, exp_lo);
      end
    end
  end

  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    req_valid = 1;
    req_op = op;
    req_src1 = a;
    req_src2 = b;
    {exp_hi, exp_lo} = model(op, a, b);
    exp_cyc = cyc + lat_of(op);
    m_act = 1;
  endtask

  task automatic run_op(input logic [1:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit pin,
                        input logic [31:0] phi,
                        input logic [31:0] plo);
    issue(op, a, b);
    repeat (lat_of(op)) @(posedge clk);
    #1;
    if (pin) begin
      chk("pin_hi", hi_wdata, phi);
      chk("pin_lo", lo_wdata, plo);
      chk("pin_done", 32'(done), 32'h1);
    end
    @(posedge clk);
    #1;
    req_valid = 0;
  endtask

  task automatic flush_after(input int k);
    repeat (k) @(posedge clk);
    #1;
    flush = 1;
    req_valid = 0;
    m_act = 0;
    @(posedge clk);
    #1;
    flush = 0;
  endtask

  initial begin
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    reset = 1;
    req_valid = 0;
    req_op = 0;
    req_src1 = 0;
    req_src2 = 0;
    flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_we", 32'(hi_we | lo_we), 32'h0);
    chk("rst_hi", hi_wdata, 32'h0);
    chk("rst_lo", lo_wdata, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    reset = 0;
    @(posedge clk);
    #1;

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1,
           32'hFFFFFFFE, 32'h00000001);
    run_op(2'b00, 32'hFFFFFFFE, 32'd3, 1,
           32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 1,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op(2'b11, 32'd100, 32'd7, 1,
           32'd2, 32'd14);
    run_op(2'b11, 32'd5, 32'd0, 1,
           32'd5, 32'hFFFFFFFF);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1,
           32'h0, 32'h80000000);

    issue(2'b10, 32'd1234, 32'd5);
    flush_after(10);
    run_op(2'b11, 32'd9, 32'd3, 1, 32'd0, 32'd3);

    // flush beats a launch in the same cycle
    req_valid = 1;
    req_op = 2'b00;
    req_src1 = 32'd4;
    req_src2 = 32'd5;
    flush = 1;
    m_act = 0;
    @(posedge clk);
    #1;
    flush = 0;
    run_op(2'b00, 32'd4, 32'd5, 1, 32'd0, 32'd20);

    issue(2'b10, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1;
    reset = 1;
    req_valid = 0;
    m_act = 0;
    @(posedge clk);
    #1;
    chk("rst2_done", 32'(done), 32'h0);
    chk("rst2_we", 32'(hi_we | lo_we), 32'h0);
    chk("rst2_hi", hi_wdata, 32'h0);
    chk("rst2_lo", lo_wdata, 32'h0);
    chk("rst2_stall", 32'(stall), 32'h0);
    reset = 0;
    @(posedge clk);
    #1;

    run_op(2'b00, 32'd6, 32'd7, 1, 32'd0, 32'd42);
    run_op(2'b01, 32'd10, 32'd11, 1, 32'd0, 32'd110);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      a = rnd_opnd();
      b = rnd_opnd();
      if ($urandom_range(0, 7) == 0) begin
        issue(op, a, b);
        flush_after($urandom_range(1, lat_of(op) - 1));
      end else begin
        run_op(op, a, b, 0, 32'h0, 32'h0);
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Multi-cycle multiply/divide sequencer for the EXE stage. Accepts a mult/multu/div/divu request from EXE and computes the product in one cycle or the quotient/remainder over a fixed-latency radix-2 iterative divide. Holds EXE stalled until the result is ready, then issues a single HI/LO write. Replaces the vendor divider IP handshake and the ad-hoc stop logic, so every divide has deterministic latency and is abortable by an exception flush.

## Interface
Parameters:
- `DIV_ITERS`, 32: divide iterations, one quotient bit per cycle; fixed, 32-bit operands.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  EXE holds a valid mul/div instruction; held stable while `stall`=1
- `req_op`  in  2  00 mult, 01 multu, 10 div, 11 divu
- `req_src1`  in  32  rs value (dividend / multiplicand), already forwarded
- `req_src2`  in  32  rt value (divisor / multiplier)
- `flush`  in  1  exception/eret flush from WB; aborts any operation
- `stall`  out  1  EXE must not advance (`req_valid & ~done`, combinational)
- `done`  out  1  one-cycle pulse, result valid
- `hi_we`, `lo_we`  out  1 each  HI/LO register write enables, equal to `done`
- `hi_wdata`  out  32  mult: product[63:32]; div: remainder
- `lo_wdata`  out  32  mult: product[31:0]; div: quotient

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: if `req_valid & ~flush`, latch op. Mult → MUL. Div: latch operand magnitudes (unsigned ops use them as-is), quotient sign = src1[31]^src2[31], remainder sign = src1[31] for signed; → DIV with counter=0.
- MUL: 33×33 signed product of sign- or zero-extended sources; register bits [63:0] → DONE.
- DIV: one restoring step per cycle, counter 0..31; at counter 31 → FIX.
- FIX: negate quotient/remainder per the latched signs (signed only) → DONE.
- DONE: `done`=1, write HI/LO, → IDLE unconditionally. A new request is sampled in IDLE the following cycle.
- Divide by zero: quotient 0xFFFFFFFF before sign fix, remainder = |src1|; normal latency; no exception.
- 0x80000000 div 0xFFFFFFFF: q=0x80000000, r=0.
- `flush` in any state → IDLE next edge; no `done`, no HI/LO write. `flush` has priority over a same-cycle launch.
- `reset`: state IDLE, counter 0, all result registers 0, `done`/`hi_we`/`lo_we`=0.

## Timing
- T = cycle the request is sampled in IDLE.
- Mult: MUL at T+1, DONE at T+2; `stall` high T..T+1, low at T+2.
- Div: DIV T+1..T+32, FIX T+33, DONE T+34.
- HI/LO are updated at the clock edge closing the DONE cycle. EXE advances on that edge.
- Back-to-back ops: next request sampled the cycle after DONE (1 idle bubble).
- `stall` is combinational from `req_valid` and `done`; `done` and the write data are registered state.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings (`OP_MULT`..`OP_DIVU`)
  - state enum
  - `DIV_ITERS`
  - latency constants `MUL_LAT`=2, `DIV_LAT`=34
- Sub-module `div_iter`: unsigned 32/32 restoring divider with start pulse, 5-bit counter, remainder/quotient shift registers and a `last` flag. `muldiv_seq` owns sign handling, the FSM and flush.

## Test plan
- multu 0xFFFFFFFF×0xFFFFFFFF → at T+2 `done`=1, HI=0xFFFFFFFE, LO=0x00000001; `stall` high exactly 2 cycles.
- mult 0xFFFFFFFE(-2)×3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA at T+2.
- div -7/2 → at T+34 LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/7 → LO=14, HI=2.
- divu 5/0 → LO=0xFFFFFFFF, HI=5 at T+34. Signed 0x80000000 div -1 → LO=0x80000000, HI=0.
- Flush mid-operation: `flush` at T+10 of a div → no `done`/`hi_we` ever for that op, IDLE at T+11. New divu 9/3 at T+11 → LO=3, HI=0 at T+45.
- Reset at T+5 of a div → all outputs 0 next cycle. Two consecutive mults → `done` at T+2 and T+5.
